heart_rate_sequencer: RTL and testbench
=======================================

// Module: heart_rate_sequencer
// PURPOSE
//  Sequences the heart-rate datapath: fixed-rate sample timer, sample request to SPI front end,
//  one-cycle strobe of each sample into filter/peak detector, peak counting over a window.
//  Converts peaks per window to BPM for the display path. Sits between spi_slave and filter/display.
// PARAMETERS
//  SAMPLE_DIV      200000  clk cycles per sample period (200 Hz at 40 MHz)
//  WINDOW_SAMPLES  3000    samples per measurement window (15 s)
//  BPM_SCALE       4       peaks->BPM multiplier (60 s / window length)
//  TIMEOUT         1000    max cycles in REQ awaiting sample_valid; elaboration error unless TIMEOUT+4 <= SAMPLE_DIV
//  REFRACT_SAMPLES 60      samples after a counted peak during which peaks are ignored (REFRACTORY_EN only)
// PORTS
//  clk            in   1   system clock, all logic on posedge
//  reset          in   1   asynchronous, active-high reset
//  start          in   1   begin continuous measurement (ignored while busy)
//  stop           in   1   abort measurement, return to IDLE
//  sample_req     out  1   level request for one new sample
//  sample_valid   in   1   sample_in valid this cycle (accepted only while sample_req=1)
//  sample_in      in   10  raw voltage sample
//  proc_en        out  1   one-cycle strobe: proc_sample valid for filter/detector
//  proc_sample    out  10  registered copy of accepted sample
//  peak_pulse     in   1   single-cycle peak indication from detector
//  bpm            out  8   last computed BPM, saturating
//  bpm_valid      out  1   one-cycle pulse when bpm updates
//  sample_timeout out  1   sticky: a sample request timed out
//  busy           out  1   1 in any state other than IDLE
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; tick_cnt, sample_cnt, peak_cnt, to_cnt, refract_cnt = 0.
//  States IDLE, TICKWAIT, REQ, PROC, REPORT. Outputs Moore: sample_req=(REQ), proc_en=(PROC).
//  IDLE: start -> TICKWAIT; clears tick_cnt, sample_cnt, peak_cnt, refract_cnt, sample_timeout.
//  tick_cnt free-runs 0..SAMPLE_DIV-1 while busy (wraps to 0).
//  TICKWAIT: tick_cnt==SAMPLE_DIV-1 -> REQ; first sample_req exactly SAMPLE_DIV cycles after start.
//  REQ: to_cnt increments each cycle. sample_valid -> latch sample_in to proc_sample, -> PROC.
//   to_cnt==TIMEOUT-1 without valid -> sample_timeout<=1, sample dropped, -> TICKWAIT.
//   sample_valid in the timeout cycle wins (sample accepted). to_cnt cleared on leaving REQ.
//  PROC (1 cycle): proc_en=1; sample_cnt++. If new count==WINDOW_SAMPLES -> REPORT else TICKWAIT.
//   Latency sample_valid -> proc_en: 1 cycle.
//  REPORT (1 cycle): bpm<=min(peak_cnt*BPM_SCALE,255) (compute in 16 bits, then clamp);
//   bpm_valid=1; sample_cnt<=0; peak_cnt<=peak_pulse?1:0; -> TICKWAIT (continuous windows).
//  Peak counting: any cycle while busy (outside REPORT), peak_pulse=1 -> peak_cnt++ (8b, saturates at 255).
//  stop (any busy state) -> IDLE next edge; bpm and sample_timeout retained; no bpm_valid; stop beats start.
//  start while busy: ignored. sample_valid outside REQ: ignored.
//  Reset mid-operation: immediate return to reset values (bpm cleared to 0).
// CONFIGURATION
//  HRS_REFRACTORY_EN defined: after a counted peak, refract_cnt<=REFRACT_SAMPLES; decrements on each
//   proc_en; peak_pulse ignored while refract_cnt!=0. refract_cnt persists across windows; cleared by start/reset.
//  Undefined: no refractory logic; every peak_pulse cycle counts.
// TESTING (bench params SAMPLE_DIV=8, WINDOW_SAMPLES=4, BPM_SCALE=4, TIMEOUT=3, REFRACT_SAMPLES=2)
//  Start pulse -> busy=1 next cycle; sample_req high 8 cycles after start; valid with 10'h155 -> proc_en 1 cycle later, proc_sample=10'h155.
//  4 samples served, 3 peak_pulses in window -> bpm=12, bpm_valid high exactly 1 cycle, new window begins.
//  70 peak_pulses in one window -> bpm=255 (saturated), bpm_valid=1.
//  sample_valid held low in REQ -> sample_timeout=1 after 3 cycles, no proc_en, sample_cnt unchanged, next req one period later.
//  stop mid-window after bpm=12 -> IDLE, busy=0, bpm stays 12, no bpm_valid; restart -> fresh counts.
//  Peaks 1 sample apart -> 1 counted with HRS_REFRACTORY_EN, 2 without.

Source files
------------

// File: rtl/heart_rate_sequencer.sv
// Heart-rate datapath sequencer: sample timer, SPI sample request, processing strobe and BPM per window.
// Optional build macro HRS_REFRACTORY_EN adds a peak refractory period counted in processed samples.
module heart_rate_sequencer #(
    parameter int SAMPLE_DIV      = 200000,
    parameter int WINDOW_SAMPLES  = 3000,
    parameter int BPM_SCALE       = 4,
    parameter int TIMEOUT         = 1000,
    parameter int REFRACT_SAMPLES = 60,
    parameter int DATA_W          = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    output logic              sample_req,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_in,
    output logic              proc_en,
    output logic [DATA_W-1:0] proc_sample,
    input  logic              peak_pulse,
    output logic [7:0]        bpm,
    output logic              bpm_valid,
    output logic              sample_timeout,
    output logic              busy
);

    localparam int TICK_W   = $clog2(SAMPLE_DIV);
    localparam int SAMPLE_W = $clog2(WINDOW_SAMPLES + 1);
    localparam int TO_W     = $clog2(TIMEOUT + 1);

    localparam logic [TICK_W-1:0]   TICK_LAST = TICK_W'(SAMPLE_DIV - 1);
    localparam logic [SAMPLE_W-1:0] WIN_LAST  = SAMPLE_W'(WINDOW_SAMPLES - 1);
    localparam logic [TO_W-1:0]     TO_LAST   = TO_W'(TIMEOUT - 1);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] TICKWAIT = 3'd1;
    localparam logic [2:0] REQ      = 3'd2;
    localparam logic [2:0] PROC     = 3'd3;
    localparam logic [2:0] REPORT   = 3'd4;

    // The request plus processing/report cycles must finish before the next tick wrap.
    generate
        if (TIMEOUT + 4 > SAMPLE_DIV) begin : g_bad_timeout
            $error("heart_rate_sequencer: TIMEOUT+4 must not exceed SAMPLE_DIV");
        end
    endgenerate

    logic [2:0]          state;
    logic [TICK_W-1:0]   tick_cnt;
    logic [SAMPLE_W-1:0] sample_cnt;
    logic [7:0]          peak_cnt;
    logic [TO_W-1:0]     to_cnt;
    logic                peak_ok;

    function automatic logic [7:0] sat_bpm(input logic [7:0] peaks);
        logic [15:0] prod;
        prod = 16'(peaks) * 16'(BPM_SCALE);
        return (prod > 16'd255) ? 8'd255 : prod[7:0];
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

`ifdef HRS_REFRACTORY_EN
    localparam int REF_W = $clog2(REFRACT_SAMPLES + 1);
    logic [REF_W-1:0] refract_cnt;

    assign peak_ok = peak_pulse && (refract_cnt == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            refract_cnt <= '0;
        end else if (state == IDLE) begin
            if (start && !stop)
                refract_cnt <= '0;
        end else if (!stop) begin
            // A newly counted peak reloads the window even on a processing cycle.
            if (peak_ok)
                refract_cnt <= REF_W'(REFRACT_SAMPLES);
            else if (state == PROC && refract_cnt != '0)
                refract_cnt <= refract_cnt - 1'b1;
        end
    end
`else
    assign peak_ok = peak_pulse;
`endif

    assign sample_req = (state == REQ);
    assign proc_en    = (state == PROC);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            tick_cnt       <= '0;
            sample_cnt     <= '0;
            peak_cnt       <= '0;
            to_cnt         <= '0;
            proc_sample    <= '0;
            bpm            <= '0;
            bpm_valid      <= 1'b0;
            sample_timeout <= 1'b0;
        end else begin
            bpm_valid <= 1'b0;
            if (state == IDLE) begin
                if (start && !stop) begin
                    state          <= TICKWAIT;
                    tick_cnt       <= '0;
                    sample_cnt     <= '0;
                    peak_cnt       <= '0;
                    to_cnt         <= '0;
                    sample_timeout <= 1'b0;
                end
            end else if (stop) begin
                state  <= IDLE;
                to_cnt <= '0;
            end else begin
                tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
                if (state != REPORT && peak_ok)
                    peak_cnt <= sat_inc8(peak_cnt);

                case (state)
                    TICKWAIT: begin
                        if (tick_cnt == TICK_LAST)
                            state <= REQ;
                    end
                    REQ: begin
                        // A valid arriving in the last allowed cycle still wins over the timeout.
                        if (sample_valid) begin
                            proc_sample <= sample_in;
                            to_cnt      <= '0;
                            state       <= PROC;
                        end else if (to_cnt == TO_LAST) begin
                            sample_timeout <= 1'b1;
                            to_cnt         <= '0;
                            state          <= TICKWAIT;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                    end
                    PROC: begin
                        sample_cnt <= sample_cnt + 1'b1;
                        state      <= (sample_cnt == WIN_LAST) ? REPORT : TICKWAIT;
                    end
                    REPORT: begin
                        bpm        <= sat_bpm(peak_cnt);
                        bpm_valid  <= 1'b1;
                        sample_cnt <= '0;
                        peak_cnt   <= peak_ok ? 8'd1 : 8'd0;
                        state      <= TICKWAIT;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_heart_rate_sequencer.sv
// Directed bench for heart_rate_sequencer with small timing parameters.
module tb_heart_rate_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       stop;
    logic       sample_req;
    logic       sample_valid;
    logic [9:0] sample_in;
    logic       proc_en;
    logic [9:0] proc_sample;
    logic       peak_pulse;
    logic [7:0] bpm;
    logic       bpm_valid;
    logic       sample_timeout;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef HRS_REFRACTORY_EN
    localparam int EXP_W1  = 8;
    localparam int EXP_E   = 4;
    localparam int EXP_SAT = 4;
`else
    localparam int EXP_W1  = 12;
    localparam int EXP_E   = 8;
    localparam int EXP_SAT = 255;
`endif

    heart_rate_sequencer #(
        .SAMPLE_DIV(8), .WINDOW_SAMPLES(4), .BPM_SCALE(4),
        .TIMEOUT(3), .REFRACT_SAMPLES(2), .DATA_W(10)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .sample_req(sample_req), .sample_valid(sample_valid), .sample_in(sample_in),
        .proc_en(proc_en), .proc_sample(proc_sample), .peak_pulse(peak_pulse),
        .bpm(bpm), .bpm_valid(bpm_valid), .sample_timeout(sample_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(output int n);
        n = 0;
        while (sample_req !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk("req_seen", int'(sample_req), 1);
    endtask

    task automatic serve(input logic [9:0] v, input string tag);
        int n;
        wait_req(n);
        sample_valid = 1'b1;
        sample_in    = v;
        step();
        sample_valid = 1'b0;
        chk({tag, "_proc_en"}, int'(proc_en), 1);
        chk({tag, "_sample"}, int'(proc_sample), int'(v));
    endtask

    task automatic peak();
        step();
        peak_pulse = 1'b1;
        step();
        peak_pulse = 1'b0;
    endtask

    task automatic report_chk(input int exp_bpm, input string tag);
        int cnt = 0;
        int cap = -1;
        repeat (4) begin
            step();
            if (bpm_valid === 1'b1) begin
                cnt++;
                cap = int'(bpm);
            end
        end
        chk({tag, "_pulses"}, cnt, 1);
        chk({tag, "_bpm"}, cap, exp_bpm);
    endtask

    task automatic no_report(input string tag);
        int cnt = 0;
        repeat (4) begin
            step();
            if (bpm_valid === 1'b1) cnt++;
        end
        chk({tag, "_no_bpm_valid"}, cnt, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, summary not reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int seen;
        reset = 1'b1; start = 1'b0; stop = 1'b0;
        sample_valid = 1'b0; sample_in = '0; peak_pulse = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        step();
        chk("rst_busy", int'(busy), 0);
        chk("rst_req", int'(sample_req), 0);
        chk("rst_proc_en", int'(proc_en), 0);
        chk("rst_proc_sample", int'(proc_sample), 0);
        chk("rst_bpm", int'(bpm), 0);
        chk("rst_bpm_valid", int'(bpm_valid), 0);
        chk("rst_timeout", int'(sample_timeout), 0);

        // Start and first-request latency
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_busy", int'(busy), 1);
        wait_req(n);
        chk("first_req_delay", n, 8);
        serve(10'h155, "s1");
        peak();

        // Request left unanswered times out after three cycles
        wait_req(n);
        seen = 0;
        step(); seen |= int'(proc_en);
        step(); seen |= int'(proc_en);
        chk("to_not_yet", int'(sample_timeout), 0);
        chk("to_req_held", int'(sample_req), 1);
        step(); seen |= int'(proc_en);
        chk("to_sticky", int'(sample_timeout), 1);
        chk("to_req_drop", int'(sample_req), 0);
        chk("to_no_proc", seen, 0);
        wait_req(n);
        chk("to_next_req", n, 5);
        serve(10'h0AA, "s2");
        peak();
        serve(10'h123, "s3");
        peak();
        serve(10'h3C0, "s4");
        report_chk(EXP_W1, "win1");
        chk("win1_busy", int'(busy), 1);
        chk("win1_timeout_kept", int'(sample_timeout), 1);

        // Stop mid-window keeps bpm and timeout, stop beats start
        serve(10'h2AA, "s5");
        peak();
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("stop_busy", int'(busy), 0);
        chk("stop_req", int'(sample_req), 0);
        chk("stop_bpm", int'(bpm), EXP_W1);
        chk("stop_timeout", int'(sample_timeout), 1);
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        chk("stop_beats_start", int'(busy), 0);
        seen = 0;
        repeat (3) begin
            step();
            seen |= int'(bpm_valid);
        end
        chk("stop_no_bpm_valid", seen, 0);
        chk("stop_bpm_hold", int'(bpm), EXP_W1);

        // Restart: fresh counts, peaks one sample apart, stray inputs ignored
        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart_busy", int'(busy), 1);
        chk("restart_to_clr", int'(sample_timeout), 0);
        serve(10'h001, "e1");
        peak();
        sample_valid = 1'b1;
        sample_in    = 10'h3FF;
        step();
        sample_valid = 1'b0;
        chk("stray_valid_proc_en", int'(proc_en), 0);
        chk("stray_valid_sample", int'(proc_sample), 10'h001);
        serve(10'h200, "e2");
        peak();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_busy_ignored", int'(busy), 1);
        serve(10'h0F0, "e3");
        no_report("e3");
        serve(10'h30F, "e4");
        report_chk(EXP_E, "win2");

        // 70 peak cycles in one window saturate bpm
        peak_pulse = 1'b1;
        repeat (70) step();
        peak_pulse = 1'b0;
        serve(10'h011, "f1");
        serve(10'h022, "f2");
        serve(10'h033, "f3");
        serve(10'h044, "f4");
        report_chk(EXP_SAT, "sat");

        // Asynchronous reset mid-operation
        step();
        #2 reset = 1'b1;
        #1;
        chk("areset_bpm", int'(bpm), 0);
        chk("areset_busy", int'(busy), 0);
        chk("areset_timeout", int'(sample_timeout), 0);
        step();
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
